// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control unit: opcodes, instruction field
// positions, FSM state encoding and the legal-opcode check.
package alu_ctrl_pkg;

    // ALU opcodes
    localparam logic [5:0] OP_ADD = 6'h01;
    localparam logic [5:0] OP_SUB = 6'h02;
    localparam logic [5:0] OP_EQ  = 6'h03;
    localparam logic [5:0] OP_NE  = 6'h04;
    localparam logic [5:0] OP_LE  = 6'h05;
    localparam logic [5:0] OP_GT  = 6'h06;
    localparam logic [5:0] OP_LLS = 6'h07;
    localparam logic [5:0] OP_LRS = 6'h08;
    localparam logic [5:0] OP_ARS = 6'h09;
    localparam logic [5:0] OP_LDI = 6'h3F;

    // Instruction field positions
    localparam int OP_MSB      = 31;
    localparam int OP_LSB      = 26;
    localparam int RD_MSB      = 25;
    localparam int RD_LSB      = 23;
    localparam int RS1_MSB     = 22;
    localparam int RS1_LSB     = 20;
    localparam int RS2_MSB     = 19;
    localparam int RS2_LSB     = 17;
    localparam int USE_IMM_BIT = 16;
    localparam int IMM_W       = 16;
    localparam int REG_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_EQ, OP_NE, OP_LE, OP_GT,
            OP_LLS, OP_LRS, OP_ARS, OP_LDI: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// r0 hardwired to zero, asynchronous active-low clear of all entries.
module alu_regfile #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(NREGS)-1:0] raddr_a,
    input  logic [$clog2(NREGS)-1:0] raddr_b,
    output logic [DATA_W-1:0]        rdata_a,
    output logic [DATA_W-1:0]        rdata_b,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata
);

    logic [NREGS-1:0][DATA_W-1:0] regs;

    // Storage; writes to r0 are dropped so it stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            regs <= '0;
        else if (we && waddr != '0)
            regs[waddr] <= wdata;
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/alu_ctrl_unit.sv
// Multi-cycle ALU control unit: accept instruction, read operands, drive the
// external combinational ALU, write back the result and hand it out on a
// response handshake. One instruction in flight at a time.
module alu_ctrl_unit
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 8,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,
    input  logic              alu_neg,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_n,
    output logic              busy
);

    state_t state, state_nxt;
    logic [31:0] instr_q;

    // Decoded fields of the latched instruction
    logic [5:0]        op;
    logic [REG_W-1:0]  rd, rs1, rs2;
    logic              use_imm;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] imm_ext;
    logic              legal, is_ldi, is_arith;

    assign op       = instr_q[OP_MSB:OP_LSB];
    assign rd       = instr_q[RD_MSB:RD_LSB];
    assign rs1      = instr_q[RS1_MSB:RS1_LSB];
    assign rs2      = instr_q[RS2_MSB:RS2_LSB];
    assign use_imm  = instr_q[USE_IMM_BIT];
    assign imm      = instr_q[IMM_W-1:0];
    assign imm_ext  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign legal    = is_legal_op(op);
    assign is_ldi   = (op == OP_LDI);
    assign is_arith = (op == OP_ADD) || (op == OP_SUB);

    // LDI bypasses the ALU result
    logic [DATA_W-1:0] rdata_a, rdata_b, wb_data;
    logic              rf_we;

    assign wb_data = is_ldi ? imm_ext : alu_result;
    assign rf_we   = (state == ST_EXEC) && legal;

    alu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (rs1),
        .raddr_b (rs2),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .we      (rf_we),
        .waddr   (rd),
        .wdata   (wb_data)
    );

    assign instr_ready = (state == ST_IDLE);
    assign rsp_valid   = (state == ST_RESP);
    assign busy        = (state != ST_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: fixed walk through the phases, RESP waits on the consumer
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (instr_valid) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC:   state_nxt = ST_RESP;
            ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: latch instruction, issue operands, capture result and flags.
    // Illegal ops touch neither the ALU operands nor the architectural state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            flag_c   <= 1'b0;
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (instr_valid) instr_q <= instr;
                ST_DECODE: if (legal) begin
                    alu_a  <= rdata_a;
                    alu_b  <= use_imm ? imm_ext : rdata_b;
                    alu_op <= op;
                end
                ST_EXEC: begin
                    if (legal) begin
                        rsp_data <= wb_data;
                        rsp_err  <= 1'b0;
                        if (!is_ldi) begin
                            flag_z <= alu_zero;
                            flag_n <= alu_neg;
                            flag_c <= is_arith ? alu_carry : 1'b0;
                        end
                    end else begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Directed bench for alu_ctrl_unit with a behavioural 32-bit ALU model.
module tb_alu_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_a, alu_b;
    logic [5:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_carry, alu_zero, alu_neg;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        flag_c, flag_z, flag_n, busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] ex_a, ex_b, r_data;
    logic [5:0]  ex_op;
    logic        r_err;

    always #5 clk = ~clk;

    alu_ctrl_unit #(.DATA_W(32), .NREGS(8), .OP_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .alu_zero(alu_zero), .alu_neg(alu_neg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .busy(busy)
    );

    // Behavioural ALU
    logic [32:0] m_sum;
    always_comb begin
        m_sum      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = 32'h0;
        alu_carry  = 1'b0;
        case (alu_op)
            6'h01: begin alu_result = m_sum[31:0]; alu_carry = m_sum[32]; end
            6'h02: begin alu_result = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
            6'h03: alu_result = {31'h0, alu_a == alu_b};
            6'h04: alu_result = {31'h0, alu_a != alu_b};
            6'h05: alu_result = {31'h0, $signed(alu_a) <= $signed(alu_b)};
            6'h06: alu_result = {31'h0, $signed(alu_a) > $signed(alu_b)};
            6'h07: alu_result = alu_a << alu_b[4:0];
            6'h08: alu_result = alu_a >> alu_b[4:0];
            6'h09: alu_result = $signed(alu_a) >>> alu_b[4:0];
            default: alu_result = 32'h0;
        endcase
        alu_zero = (alu_result == 32'h0);
        alu_neg  = alu_result[31];
    end

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2,
                                        input logic ui, input logic [15:0] imm);
        return {op, rd, rs1, rs2, ui, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic c, input logic z, input logic n);
        chk(tag, {29'h0, flag_c, flag_z, flag_n}, {29'h0, c, z, n});
    endtask

    // Issue one instruction; capture operands during EXEC and the response in
    // RESP. rsp_valid must be low in EXEC and high one edge later (the third
    // edge counting the accept edge). Returns in IDLE when rsp_ready is high.
    task automatic run(input logic [31:0] ins);
        int n;
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("ready_timeout", {31'h0, instr_ready}, 32'h1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        ex_a = alu_a; ex_b = alu_b; ex_op = alu_op;
        chk("lat_exec_valid_low", {31'h0, rsp_valid}, 32'h0);
        @(posedge clk); #1;
        chk("lat_resp_valid", {31'h0, rsp_valid}, 32'h1);
        r_data = rsp_data;
        r_err  = rsp_err;
        if (rsp_ready) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr = 32'h0; rsp_ready = 1'b1;
        #12;
        @(negedge clk); rst_n = 1'b1; #1;
        // Reset state
        chk("rst_instr_ready", {31'h0, instr_ready}, 32'h1);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        chk("rst_alu_op", {26'h0, alu_op}, 32'h0);
        chk_flags("rst_flags", 0, 0, 0);

        // LDI sign extension
        run(enc(6'h3F, 3'd1, 3'd0, 3'd0, 1'b1, 16'h7FFF));
        chk("ldi_pos_data", r_data, 32'h0000_7FFF);
        chk("ldi_pos_err", {31'h0, r_err}, 32'h0);
        chk("ldi_alu_op", {26'h0, ex_op}, 32'h3F);
        chk_flags("ldi_flags_kept", 0, 0, 0);
        run(enc(6'h3F, 3'd2, 3'd0, 3'd0, 1'b1, 16'hFFFF));
        chk("ldi_neg_data", r_data, 32'hFFFF_FFFF);
        chk("ldi_neg_err", {31'h0, r_err}, 32'h0);

        // r1 = -1, r2 = 1, ADD wraps with carry
        run(enc(6'h3F, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF));
        run(enc(6'h3F, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0001));
        run(enc(6'h01, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000));
        chk("add_alu_a", ex_a, 32'hFFFF_FFFF);
        chk("add_alu_b", ex_b, 32'h1);
        chk("add_alu_op", {26'h0, ex_op}, 32'h01);
        chk("add_data", r_data, 32'h0);
        chk_flags("add_flags", 1, 1, 0);

        // r4 = 1 << 31, then ARS by 4
        run(enc(6'h07, 3'd4, 3'd2, 3'd0, 1'b1, 16'd31));
        chk("lls_data", r_data, 32'h8000_0000);
        chk_flags("lls_flags", 0, 0, 1);
        run(enc(6'h09, 3'd5, 3'd4, 3'd0, 1'b1, 16'd4));
        chk("ars_data", r_data, 32'hF800_0000);
        chk_flags("ars_flags", 0, 0, 1);

        // SUB into r0: value reported, r0 stays zero
        run(enc(6'h02, 3'd0, 3'd4, 3'd4, 1'b0, 16'h0));
        chk("sub_r0_data", r_data, 32'h0);
        chk_flags("sub_flags", 0, 1, 0);
        run(enc(6'h01, 3'd6, 3'd0, 3'd5, 1'b0, 16'h0));
        chk("r0_reads_zero", ex_a, 32'h0);
        chk("add_r0_r5_data", r_data, 32'hF800_0000);
        chk_flags("add_r0_r5_flags", 0, 0, 1);

        // Illegal opcode
        run(enc(6'h20, 3'd5, 3'd2, 3'd3, 1'b1, 16'h1234));
        chk("ill_err", {31'h0, r_err}, 32'h1);
        chk("ill_data", r_data, 32'h0);
        chk("ill_alu_op_kept", {26'h0, ex_op}, 32'h01);
        chk("ill_alu_a_kept", ex_a, 32'h0);
        chk("ill_alu_b_kept", ex_b, 32'hF800_0000);
        chk_flags("ill_flags_kept", 0, 0, 1);
        run(enc(6'h01, 3'd7, 3'd5, 3'd0, 1'b0, 16'h0));
        chk("ill_r5_kept", ex_a, 32'hF800_0000);

        // Backpressure with a competing instruction offered
        rsp_ready = 1'b0;
        run(enc(6'h3F, 3'd6, 3'd0, 3'd0, 1'b1, 16'h0042));
        chk("bp_data", r_data, 32'h42);
        @(negedge clk);
        instr = enc(6'h3F, 3'd6, 3'd0, 3'd0, 1'b1, 16'h0055);
        instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid_held", {31'h0, rsp_valid}, 32'h1);
            chk("bp_data_held", rsp_data, 32'h42);
            chk("bp_instr_ready", {31'h0, instr_ready}, 32'h0);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", {30'h0, busy, instr_ready}, 32'h1);
        chk("bp_release_valid", {31'h0, rsp_valid}, 32'h0);
        run(enc(6'h01, 3'd7, 3'd6, 3'd0, 1'b0, 16'h0));
        chk("bp_ignored_instr", r_data, 32'h42);
        chk_flags("bp_add_flags", 0, 0, 0);

        // Make flags nonzero, then reset in EXEC
        run(enc(6'h01, 3'd7, 3'd5, 3'd0, 1'b0, 16'h0));
        @(negedge clk);
        instr = enc(6'h3F, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {31'h0, busy}, 32'h0);
        chk("rst_mid_valid", {31'h0, rsp_valid}, 32'h0);
        chk_flags("rst_mid_flags", 0, 0, 0);
        chk("rst_mid_alu_a", alu_a, 32'h0);
        chk("rst_mid_alu_op", {26'h0, alu_op}, 32'h0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rst_mid_ready", {31'h0, instr_ready}, 32'h1);
        run(enc(6'h01, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0));
        chk("rst_r1_zero", ex_a, 32'h0);
        chk("rst_r2_zero", ex_b, 32'h0);
        run(enc(6'h01, 3'd3, 3'd5, 3'd6, 1'b0, 16'h0));
        chk("rst_r5_zero", ex_a, 32'h0);
        chk("rst_r6_zero", ex_b, 32'h0);
        chk("rst_sum_zero", r_data, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
